id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
- Sits directly upstream of the ALU and drives its porta, portb and ALUOP each cycle.
- Captures decoded instruction fields and forwards results from EX/MEM and MEM/WB.
- Stalls decode for one cycle on a load-use hazard.

---
 rtl/id_ex_operand_stage_if.sv | 76 +++++++
 rtl/id_ex_operand_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle for id_ex_operand_stage: decode fields, forwarding sources, ALU drive.
// Perf counter signals exist only when IDEX_PERF_CNT_EN is defined.
interface id_ex_operand_stage_if #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
);
  logic           en;
  logic           flush;
  logic           id_valid;
  logic [OPW-1:0] id_aluop;
  logic [RW-1:0]  id_rs;
  logic [RW-1:0]  id_rt;
  logic [RW-1:0]  id_wsel;
  logic           id_uses_rs;
  logic           id_uses_rt;
  logic [DW-1:0]  id_rdat1;
  logic [DW-1:0]  id_rdat2;
  logic [DW-1:0]  id_imm;
  logic [4:0]     id_shamt;
  logic           id_alusrc;
  logic           id_shift;
  logic           id_regwrite;
  logic           id_memread;
  logic           id_memwrite;
  logic           exmem_regwrite;
  logic           exmem_memread;
  logic [RW-1:0]  exmem_wsel;
  logic [DW-1:0]  exmem_result;
  logic           memwb_regwrite;
  logic [RW-1:0]  memwb_wsel;
  logic [DW-1:0]  memwb_wdat;
  logic           stall;
  logic           ex_valid;
  logic           ex_regwrite;
  logic           ex_memread;
  logic           ex_memwrite;
  logic [RW-1:0]  ex_wsel;
  logic [OPW-1:0] alu_aluop;
  logic [DW-1:0]  alu_porta;
  logic [DW-1:0]  alu_portb;
  logic [DW-1:0]  ex_store_data;
`ifdef IDEX_PERF_CNT_EN
  logic           perf_clr;
  logic [31:0]    perf_stall_cnt;
  logic [31:0]    perf_fwd_cnt;
`endif

  modport master (
`ifdef IDEX_PERF_CNT_EN
    output perf_clr,
    input  perf_stall_cnt, perf_fwd_cnt,
`endif
    output en, flush, id_valid, id_aluop, id_rs, id_rt, id_wsel,
           id_uses_rs, id_uses_rt, id_rdat1, id_rdat2, id_imm, id_shamt,
           id_alusrc, id_shift, id_regwrite, id_memread, id_memwrite,
           exmem_regwrite, exmem_memread, exmem_wsel, exmem_result,
           memwb_regwrite, memwb_wsel, memwb_wdat,
    input  stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_wsel,
           alu_aluop, alu_porta, alu_portb, ex_store_data
  );

  modport slave (
`ifdef IDEX_PERF_CNT_EN
    input  perf_clr,
    output perf_stall_cnt, perf_fwd_cnt,
`endif
    input  en, flush, id_valid, id_aluop, id_rs, id_rt, id_wsel,
           id_uses_rs, id_uses_rt, id_rdat1, id_rdat2, id_imm, id_shamt,
           id_alusrc, id_shift, id_regwrite, id_memread, id_memwrite,
           exmem_regwrite, exmem_memread, exmem_wsel, exmem_result,
           memwb_regwrite, memwb_wsel, memwb_wdat,
    output stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_wsel,
           alu_aluop, alu_porta, alu_portb, ex_store_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with EX-stage operand forwarding and load-use stall.
// Optional saturating perf counters enabled by defining IDEX_PERF_CNT_EN.
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input logic                   CLK,
  input logic                   nRST,
  id_ex_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] aluop;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic [RW-1:0]  wsel;
    logic [DW-1:0]  rdat1;
    logic [DW-1:0]  rdat2;
    logic [DW-1:0]  imm;
    logic [4:0]     shamt;
    logic           alusrc;
    logic           shift;
    logic           regwrite;
    logic           memread;
    logic           memwrite;
  } idex_t;

  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2} fwd_e;

  idex_t         r_ex;
  idex_t         w_id;
  logic          w_stall;
  fwd_e          w_rs_sel;
  fwd_e          w_rt_sel;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  always_comb begin
    w_id          = '0;
    w_id.valid    = bus.id_valid;
    w_id.aluop    = bus.id_aluop;
    w_id.rs       = bus.id_rs;
    w_id.rt       = bus.id_rt;
    w_id.wsel     = bus.id_wsel;
    w_id.rdat1    = bus.id_rdat1;
    w_id.rdat2    = bus.id_rdat2;
    w_id.imm      = bus.id_imm;
    w_id.shamt    = bus.id_shamt;
    w_id.alusrc   = bus.id_alusrc;
    w_id.shift    = bus.id_shift;
    w_id.regwrite = bus.id_regwrite;
    w_id.memread  = bus.id_memread;
    w_id.memwrite = bus.id_memwrite;
  end

  // Load in EX whose target is read by the decode slot: one bubble suffices,
  // since next cycle the load sits in EX/MEM and is no longer visible here.
  always_comb begin
    w_stall = r_ex.valid & r_ex.memread & (r_ex.wsel != '0) & bus.id_valid &
              ((bus.id_uses_rs & (bus.id_rs == r_ex.wsel)) |
               (bus.id_uses_rt & (bus.id_rt == r_ex.wsel)));
  end

  always_ff @(posedge CLK) begin
    if (!nRST)
      r_ex <= '0;
    else if (bus.en) begin
      if (bus.flush || w_stall)
        r_ex <= '0;
      else
        r_ex <= w_id;
    end
  end

  // EX/MEM load results are not ready yet, so only non-load EX/MEM writes
  // forward; $0 is hardwired and never forwarded.
  function automatic fwd_e fwd_pick(
    input logic [RW-1:0] r,
    input logic          xm_we,
    input logic          xm_rd,
    input logic [RW-1:0] xm_ws,
    input logic          mw_we,
    input logic [RW-1:0] mw_ws
  );
    fwd_e s;
    s = FWD_NONE;
    if (r != '0) begin
      if (xm_we && !xm_rd && (xm_ws == r))
        s = FWD_EXMEM;
      else if (mw_we && (mw_ws == r))
        s = FWD_MEMWB;
    end
    return s;
  endfunction

  always_comb begin
    w_rs_sel = fwd_pick(r_ex.rs, bus.exmem_regwrite, bus.exmem_memread,
                        bus.exmem_wsel, bus.memwb_regwrite, bus.memwb_wsel);
    w_rt_sel = fwd_pick(r_ex.rt, bus.exmem_regwrite, bus.exmem_memread,
                        bus.exmem_wsel, bus.memwb_regwrite, bus.memwb_wsel);
  end

  always_comb begin
    unique case (w_rs_sel)
      FWD_EXMEM: w_fwd_rs = bus.exmem_result;
      FWD_MEMWB: w_fwd_rs = bus.memwb_wdat;
      default:   w_fwd_rs = r_ex.rdat1;
    endcase
    unique case (w_rt_sel)
      FWD_EXMEM: w_fwd_rt = bus.exmem_result;
      FWD_MEMWB: w_fwd_rt = bus.memwb_wdat;
      default:   w_fwd_rt = r_ex.rdat2;
    endcase
  end

  always_comb begin
    bus.stall         = w_stall;
    bus.ex_valid      = r_ex.valid;
    bus.ex_regwrite   = r_ex.valid & r_ex.regwrite;
    bus.ex_memread    = r_ex.valid & r_ex.memread;
    bus.ex_memwrite   = r_ex.valid & r_ex.memwrite;
    bus.ex_wsel       = r_ex.wsel;
    bus.alu_aluop     = r_ex.aluop;
    bus.alu_porta     = r_ex.shift ? w_fwd_rt : w_fwd_rs;
    if (r_ex.shift)
      bus.alu_portb   = {{(DW-5){1'b0}}, r_ex.shamt};
    else if (r_ex.alusrc)
      bus.alu_portb   = r_ex.imm;
    else
      bus.alu_portb   = w_fwd_rt;
    bus.ex_store_data = w_fwd_rt;
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_any_fwd;

  always_comb w_any_fwd = (w_rs_sel != FWD_NONE) || (w_rt_sel != FWD_NONE);

  always_ff @(posedge CLK) begin
    if (!nRST || bus.perf_clr) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (bus.en && w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.en && r_ex.valid && w_any_fwd && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  always_comb begin
    bus.perf_stall_cnt = r_stall_cnt;
    bus.perf_fwd_cnt   = r_fwd_cnt;
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, capture, forwarding, load-use,
// $0/shift handling, flush/stall/hold interactions.
module tb_id_ex_operand_stage;
  localparam logic [3:0] ALU_SLL = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.en = 1'b1;  bus.flush = 1'b0;
    bus.id_valid = 1'b1; bus.id_aluop = ALU_ADD;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_wsel = '0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_rdat1 = '0; bus.id_rdat2 = '0; bus.id_imm = '0; bus.id_shamt = '0;
    bus.id_alusrc = 1'b0; bus.id_shift = 1'b0;
    bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.id_memwrite = 1'b0;
    bus.exmem_regwrite = 1'b0; bus.exmem_memread = 1'b0;
    bus.exmem_wsel = '0; bus.exmem_result = '0;
    bus.memwb_regwrite = 1'b0; bus.memwb_wsel = '0; bus.memwb_wdat = '0;
`ifdef IDEX_PERF_CNT_EN
    bus.perf_clr = 1'b0;
`endif
  endtask

  // Places a load to $dst into EX (caller's id fields are overwritten).
  task automatic load_lw(input logic [4:0] dst, input logic [31:0] a, input logic [31:0] b);
    set_defaults();
    bus.id_memread = 1'b1; bus.id_regwrite = 1'b1; bus.id_wsel = dst;
    bus.id_rs = 5'd1; bus.id_uses_rs = 1'b1; bus.id_rdat1 = a; bus.id_rdat2 = b;
    tick();
  endtask

  task automatic test_reset();
    set_defaults();
    nrst = 1'b0;
    bus.id_rdat1 = 32'd5; bus.id_rdat2 = 32'd7; bus.id_regwrite = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.ex_valid); end
    n_cmp++; if (bus.alu_porta !== 32'd0) begin n_bad++; $display("FAIL reset_porta got %h want 0", bus.alu_porta); end
    n_cmp++; if (bus.alu_portb !== 32'd0) begin n_bad++; $display("FAIL reset_portb got %h want 0", bus.alu_portb); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
    n_cmp++; if (bus.ex_regwrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite got %0b want 0", bus.ex_regwrite); end
    nrst = 1'b1;
  endtask

  task automatic test_capture();
    set_defaults();
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_wsel = 5'd3;
    bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1;
    bus.id_rdat1 = 32'd5; bus.id_rdat2 = 32'd7; bus.id_regwrite = 1'b1;
    tick();
    n_cmp++; if (bus.alu_porta !== 32'd5) begin n_bad++; $display("FAIL cap_porta got %h want 5", bus.alu_porta); end
    n_cmp++; if (bus.alu_portb !== 32'd7) begin n_bad++; $display("FAIL cap_portb got %h want 7", bus.alu_portb); end
    n_cmp++; if (bus.alu_aluop !== ALU_ADD) begin n_bad++; $display("FAIL cap_aluop got %h want %h", bus.alu_aluop, ALU_ADD); end
    n_cmp++; if (bus.ex_wsel !== 5'd3 || bus.ex_regwrite !== 1'b1 || bus.ex_valid !== 1'b1)
      begin n_bad++; $display("FAIL cap_ctrl got wsel=%0d rw=%0b v=%0b want 3/1/1", bus.ex_wsel, bus.ex_regwrite, bus.ex_valid); end
    bus.id_alusrc = 1'b1; bus.id_imm = 32'hFFFF_FFF0;
    tick();
    n_cmp++; if (bus.alu_portb !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL cap_imm got %h want fffffff0", bus.alu_portb); end
    n_cmp++; if (bus.ex_store_data !== 32'd7) begin n_bad++; $display("FAIL cap_store got %h want 7", bus.ex_store_data); end
    bus.id_valid = 1'b0; bus.id_memwrite = 1'b1;
    tick();
    n_cmp++; if (bus.ex_regwrite !== 1'b0 || bus.ex_memwrite !== 1'b0)
      begin n_bad++; $display("FAIL invalid_ctrl got rw=%0b mw=%0b want 0/0", bus.ex_regwrite, bus.ex_memwrite); end
  endtask

  task automatic test_fwd_priority();
    set_defaults();
    bus.id_rs = 5'd8; bus.id_rt = 5'd2; bus.id_rdat1 = 32'd1; bus.id_rdat2 = 32'd2;
    tick();
    bus.exmem_regwrite = 1'b1; bus.exmem_wsel = 5'd8; bus.exmem_result = 32'h1234;
    bus.memwb_regwrite = 1'b1; bus.memwb_wsel = 5'd8; bus.memwb_wdat = 32'h9999;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'h1234) begin n_bad++; $display("FAIL fwd_exmem got %h want 1234", bus.alu_porta); end
    n_cmp++; if (bus.alu_portb !== 32'd2) begin n_bad++; $display("FAIL fwd_rt_nomatch got %h want 2", bus.alu_portb); end
    bus.exmem_memread = 1'b1;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'h9999) begin n_bad++; $display("FAIL fwd_exmem_load got %h want 9999", bus.alu_porta); end
    bus.exmem_memread = 1'b0; bus.exmem_regwrite = 1'b0;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'h9999) begin n_bad++; $display("FAIL fwd_memwb got %h want 9999", bus.alu_porta); end
    bus.memwb_regwrite = 1'b0;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'd1) begin n_bad++; $display("FAIL fwd_none got %h want 1", bus.alu_porta); end
  endtask

  task automatic test_load_use();
    load_lw(5'd9, 32'd0, 32'd0);
    bus.id_memread = 1'b0; bus.id_wsel = 5'd10;
    bus.id_rs = 5'd9; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b1;
    bus.id_rdat1 = 32'd0; bus.id_rdat2 = 32'd5;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", bus.stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %0b want 0", bus.ex_valid); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle got %0b want 0", bus.stall); end
    bus.exmem_regwrite = 1'b1; bus.exmem_memread = 1'b1; bus.exmem_wsel = 5'd9;
    tick();
    bus.exmem_regwrite = 1'b0; bus.exmem_memread = 1'b0; bus.exmem_wsel = 5'd0;
    bus.memwb_regwrite = 1'b1; bus.memwb_wsel = 5'd9; bus.memwb_wdat = 32'd42;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'd42) begin n_bad++; $display("FAIL lu_fwd got %h want 42", bus.alu_porta); end
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_wsel !== 5'd10)
      begin n_bad++; $display("FAIL lu_capture got v=%0b wsel=%0d want 1/10", bus.ex_valid, bus.ex_wsel); end
  endtask

  task automatic test_zero_shift();
    set_defaults();
    bus.id_rs = 5'd0; bus.id_rdat1 = 32'hABCD; bus.id_rt = 5'd2; bus.id_rdat2 = 32'd3;
    tick();
    bus.exmem_regwrite = 1'b1; bus.exmem_wsel = 5'd0; bus.exmem_result = 32'd77;
    bus.memwb_regwrite = 1'b1; bus.memwb_wsel = 5'd0; bus.memwb_wdat = 32'd55;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'hABCD) begin n_bad++; $display("FAIL zero_nofwd got %h want abcd", bus.alu_porta); end
    set_defaults();
    bus.id_aluop = ALU_SLL; bus.id_shift = 1'b1; bus.id_rs = 5'd0; bus.id_rdat1 = 32'd99;
    bus.id_rt = 5'd2; bus.id_rdat2 = 32'd3; bus.id_shamt = 5'd4; bus.id_imm = 32'h55;
    bus.id_alusrc = 1'b1;
    tick();
    n_cmp++; if (bus.alu_porta !== 32'd3) begin n_bad++; $display("FAIL sll_porta got %h want 3", bus.alu_porta); end
    n_cmp++; if (bus.alu_portb !== 32'd4) begin n_bad++; $display("FAIL sll_portb got %h want 4", bus.alu_portb); end
    n_cmp++; if (bus.alu_aluop !== ALU_SLL) begin n_bad++; $display("FAIL sll_aluop got %h want %h", bus.alu_aluop, ALU_SLL); end
    bus.memwb_regwrite = 1'b1; bus.memwb_wsel = 5'd2; bus.memwb_wdat = 32'd11;
    #1;
    n_cmp++; if (bus.alu_porta !== 32'd11 || bus.ex_store_data !== 32'd11)
      begin n_bad++; $display("FAIL sll_fwd got a=%h sd=%h want b/b", bus.alu_porta, bus.ex_store_data); end
  endtask

  task automatic test_flush_hold();
    load_lw(5'd9, 32'd0, 32'd0);
    bus.id_memread = 1'b0; bus.id_rs = 5'd9; bus.id_wsel = 5'd4; bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL fl_stall got %0b want 1", bus.stall); end
    tick();
    n_cmp++; if (bus.ex_regwrite !== 1'b0 || bus.ex_valid !== 1'b0)
      begin n_bad++; $display("FAIL fl_bubble got rw=%0b v=%0b want 0/0", bus.ex_regwrite, bus.ex_valid); end
    load_lw(5'd9, 32'd21, 32'd22);
    bus.en = 1'b0; bus.id_memread = 1'b0; bus.id_rs = 5'd9; bus.id_rdat1 = 32'd1; bus.id_rdat2 = 32'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.alu_porta !== 32'd21 || bus.alu_portb !== 32'd22 || bus.ex_wsel !== 5'd9 || bus.ex_memread !== 1'b1)
        begin n_bad++; $display("FAIL hold_%0d got a=%h b=%h ws=%0d mr=%0b want 15/16/9/1", i, bus.alu_porta, bus.alu_portb, bus.ex_wsel, bus.ex_memread); end
      n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL hold_stall_%0d got %0b want 1", i, bus.stall); end
    end
    bus.en = 1'b1;
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release got %0b want 0", bus.ex_valid); end
    bus.en = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.ex_valid !== 1'b0 || bus.alu_porta !== 32'd0)
      begin n_bad++; $display("FAIL hold_bubble got v=%0b a=%h want 0/0", bus.ex_valid, bus.alu_porta); end
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    load_lw(5'd7, 32'd3, 32'd4);
    bus.id_memread = 1'b0; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL rms_pre got %0b want 1", bus.stall); end
    nrst = 1'b0; bus.en = 1'b0;
    tick();
    n_cmp++; if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0)
      begin n_bad++; $display("FAIL rms_post got s=%0b v=%0b want 0/0", bus.stall, bus.ex_valid); end
    nrst = 1'b1; bus.en = 1'b1;
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_capture();
    test_fwd_priority();
    test_load_use();
    test_zero_shift();
    test_flush_hold();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
